led_driver_model: RTL and testbench

Synthesizable receiver-side model of the cube's 16-channel constant-current LED sink driver. It consumes the serial control bundle produced by the panel sequencer: sclk, sdi, le, oe_n.
- Decodes the 5-edge normal/special mode-switch handshake.
- Shifts and latches channel data (normal mode) or configuration data (special mode).
- Returns error status on sdo after an error-detect window.
It sits on the bench/loopback side of the panel interface and closes the loop for sequencer verification and on-FPGA self-test.

---
 rtl/led_drv_pkg.sv | 39 +++
 rtl/led_driver_model_if.sv | 12 +
 rtl/led_driver_model_ser_in_sync.sv | 32 +++
 rtl/led_driver_model.sv | 136 +++++++++++++
 tb/tb_led_driver_model.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/led_drv_pkg.sv
// Shared constants and types for the LED sink driver receiver model.
// Holds the default sizes, the mode-switch step pattern and the synced serial bundle layout.
package led_drv_pkg;

  localparam int unsigned DEF_CHANNELS      = 16;
  localparam int unsigned DEF_CFG_W         = 8;
  localparam logic [7:0]  DEF_CFG_RESET     = 8'hFF;
  localparam int unsigned DEF_ERR_MIN_EDGES = 3;

  // seq_cnt holds 0..4: the number of handshake steps matched so far
  localparam int unsigned SEQ_W        = 3;
  localparam int unsigned SEQ_SEL_IDX  = 3;  // step 4: le is recorded as the mode select
  localparam int unsigned SEQ_LAST_IDX = 4;  // step 5: the switch takes effect
  localparam int unsigned STEP_SLOTS   = 1 << SEQ_W;

  // Expected (oe_n, le) for each step; bit i describes step i+1
  localparam logic [STEP_SLOTS-1:0] STEP_VALID   = 8'b0001_1111;
  localparam logic [STEP_SLOTS-1:0] STEP_OE_N    = 8'b0001_1101;
  localparam logic [STEP_SLOTS-1:0] STEP_LE      = 8'b0000_0000;
  localparam logic [STEP_SLOTS-1:0] STEP_LE_CARE = 8'b0001_0111;

  // Serial control bundle as seen after synchronization
  typedef struct packed {
    logic oe_n;
    logic le;
    logic sdi;
    logic sclk;
  } ser_bits_t;

  localparam ser_bits_t SER_RST = '{oe_n: 1'b1, le: 1'b0, sdi: 1'b0, sclk: 1'b0};

  // True when the sampled (oe_n, le) matches the step following idx matched steps
  function automatic logic step_match(input logic [SEQ_W-1:0] idx, input logic oe_n,
                                      input logic le);
    return STEP_VALID[idx] && (oe_n == STEP_OE_N[idx]) &&
           (!STEP_LE_CARE[idx] || (le == STEP_LE[idx]));
  endfunction

endpackage

// File: rtl/led_driver_model_if.sv
// Serial control bundle between the panel sequencer and the LED sink driver.
// master: sequencer side (drives sclk/sdi/le/oe_n, reads sdo); slave: driver side.
interface led_driver_model_if;
  logic sclk;
  logic sdi;
  logic le;
  logic oe_n;
  logic sdo;

  modport master (output sclk, output sdi, output le, output oe_n, input sdo);
  modport slave  (input sclk, input sdi, input le, input oe_n, output sdo);
endinterface

// File: rtl/led_driver_model_ser_in_sync.sv
// N-bit two-flop synchronizer with a one-cycle delayed copy for rising-edge detection.
// Ports: clk, reset_n, d (async inputs), q (synchronized), rise_c (q rose this cycle).
module ser_in_sync #(
  parameter int unsigned    N       = 4,
  parameter logic [N-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic [N-1:0] rise_c
);

  logic [N-1:0] meta;
  logic [N-1:0] q_d;

  // All bits share the same depth so relative timing between them is preserved
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
      q_d  <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
      q_d  <= q;
    end
  end

  assign rise_c = q & ~q_d;

endmodule

// File: rtl/led_driver_model.sv
// Receiver-side model of the 16-channel constant-current LED sink driver.
// Ports: clk, reset_n; bus (slave: sclk, sdi, le, oe_n in, sdo out); err_status (readback
// flags); out_on (channel drive); cfg (configuration); special_mode (1 = configuration mode).
module led_driver_model
  import led_drv_pkg::*;
#(
  parameter int unsigned      CHANNELS      = DEF_CHANNELS,
  parameter int unsigned      CFG_W         = DEF_CFG_W,
  parameter logic [CFG_W-1:0] CFG_RESET     = CFG_W'(DEF_CFG_RESET),
  parameter int unsigned      ERR_MIN_EDGES = DEF_ERR_MIN_EDGES
) (
  input  logic                clk,
  input  logic                reset_n,
  led_driver_model_if.slave   bus,
  input  logic [CHANNELS-1:0] err_status,
  output logic [CHANNELS-1:0] out_on,
  output logic [CFG_W-1:0]    cfg,
  output logic                special_mode
);

  localparam int unsigned ERR_W = $clog2(ERR_MIN_EDGES + 1);

  ser_bits_t raw;
  ser_bits_t s;
  ser_bits_t rise;

  assign raw = '{oe_n: bus.oe_n, le: bus.le, sdi: bus.sdi, sclk: bus.sclk};

  ser_in_sync #(
    .N       ($bits(ser_bits_t)),
    .RST_VAL (SER_RST)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (raw),
    .q       (s),
    .rise_c  (rise)
  );

  logic unused_ok;
  assign unused_ok = ^{s.sclk, rise.sdi};

  logic [CHANNELS-1:0] sr,        sr_n;
  logic [CHANNELS-1:0] out_data,  out_data_n;
  logic [CHANNELS-1:0] out_on_n;
  logic [CFG_W-1:0]    cfg_n;
  logic                special_n;
  logic [SEQ_W-1:0]    seq_cnt,   seq_n;
  logic                mode_sel,  mode_sel_n;
  logic [ERR_W-1:0]    err_cnt,   err_cnt_n;
  logic                err_armed, err_armed_n;
  logic                sdo_q;

  // Next-state: shift/readback, handshake detector, latch, error arming
  always_comb begin
    sr_n        = sr;
    out_data_n  = out_data;
    cfg_n       = cfg;
    special_n   = special_mode;
    seq_n       = seq_cnt;
    mode_sel_n  = mode_sel;
    err_cnt_n   = err_cnt;
    err_armed_n = err_armed;

    if (rise.sclk) begin
      if (err_armed) begin
        sr_n        = err_status;
        err_armed_n = 1'b0;
      end else begin
        sr_n = {sr[CHANNELS-2:0], s.sdi};
      end

      if (step_match(seq_cnt, s.oe_n, s.le)) begin
        if (seq_cnt == SEQ_W'(SEQ_LAST_IDX)) begin
          special_n = mode_sel;
          seq_n     = '0;
        end else begin
          seq_n = seq_cnt + SEQ_W'(1);
          if (seq_cnt == SEQ_W'(SEQ_SEL_IDX)) mode_sel_n = s.le;
        end
      end else begin
        // A broken step may itself be a fresh step 1
        seq_n = step_match('0, s.oe_n, s.le) ? SEQ_W'(1) : '0;
      end

      if (!s.oe_n && (err_cnt != ERR_W'(ERR_MIN_EDGES))) err_cnt_n = err_cnt + ERR_W'(1);
    end

    // The le pulse of handshake step 4 is not a data latch; pre-shift SR is used
    if (rise.le && (seq_cnt != SEQ_W'(SEQ_SEL_IDX))) begin
      if (special_mode) cfg_n = sr[CFG_W-1:0];
      else              out_data_n = sr;
    end

    if (rise.oe_n && (err_cnt == ERR_W'(ERR_MIN_EDGES))) err_armed_n = 1'b1;

    if (s.oe_n || !special_mode) err_cnt_n = '0;

    if (special_n != special_mode) begin
      err_cnt_n   = '0;
      err_armed_n = 1'b0;
    end

    out_on_n = s.oe_n ? '0 : out_data;
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr           <= '0;
      out_data     <= '0;
      out_on       <= '0;
      cfg          <= CFG_RESET;
      special_mode <= 1'b0;
      seq_cnt      <= '0;
      mode_sel     <= 1'b0;
      err_cnt      <= '0;
      err_armed    <= 1'b0;
      sdo_q        <= 1'b0;
    end else begin
      sr           <= sr_n;
      out_data     <= out_data_n;
      out_on       <= out_on_n;
      cfg          <= cfg_n;
      special_mode <= special_n;
      seq_cnt      <= seq_n;
      mode_sel     <= mode_sel_n;
      err_cnt      <= err_cnt_n;
      err_armed    <= err_armed_n;
      sdo_q        <= sr[CHANNELS-1];
    end
  end

  assign bus.sdo = sdo_q;

endmodule

// File: tb/tb_led_driver_model.sv
// Scoreboard bench for led_driver_model: stimulus queues expected values, a monitor compares.
module tb_led_driver_model;
  import led_drv_pkg::*;

  localparam int unsigned CH = 16;
  localparam int K_OUT = 0, K_CFG = 1, K_SPC = 2, K_SDO = 3;

  logic          clk;
  logic          reset_n;
  logic [CH-1:0] err_status;
  logic [CH-1:0] out_on;
  logic [7:0]    cfg;
  logic          special_mode;

  led_driver_model_if bus ();

  led_driver_model dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .err_status   (err_status),
    .out_on       (out_on),
    .cfg          (cfg),
    .special_mode (special_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    int         kind;
    logic [15:0] exp;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Monitor: compares queued expectations once their sample cycle arrives
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      logic [15:0] act;
      e = sb.pop_front();
      case (e.kind)
        K_OUT:   act = out_on;
        K_CFG:   act = {8'h00, cfg};
        K_SPC:   act = {15'h0, special_mode};
        default: act = {15'h0, bus.sdo};
      endcase
      n_checks++;
      if (act === e.exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string name, input int kind, input logic [15:0] v);
    sb.push_back('{name, kind, v, cyc + 1});
    wait_clk(1);
  endtask

  // One serial bit: set data/control with sclk low, then raise sclk
  task automatic bit_step(input logic oe, input logic l, input logic d);
    bus.sclk = 1'b0; bus.oe_n = oe; bus.le = l; bus.sdi = d;
    wait_clk(3);
    bus.sclk = 1'b1;
    wait_clk(4);
  endtask

  task automatic le_pulse();
    bus.sclk = 1'b0;
    wait_clk(2);
    bus.le = 1'b1;
    wait_clk(4);
    bus.le = 1'b0;
    wait_clk(4);
  endtask

  task automatic shift_word(input logic oe, input logic [15:0] v, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) bit_step(oe, 1'b0, v[i]);
  endtask

  task automatic set_oe(input logic oe);
    bus.oe_n = oe;
    wait_clk(5);
  endtask

  // Handshake with a chosen le at step 4 (1 = special, 0 = normal)
  task automatic handshake(input logic sel);
    bit_step(1'b1, 1'b0, 1'b0);
    bit_step(1'b0, 1'b0, 1'b0);
    bit_step(1'b1, 1'b0, 1'b0);
    bit_step(1'b1, sel,  1'b0);
    bit_step(1'b1, 1'b0, 1'b0);
  endtask

  logic [15:0] exp_sdo;

  initial begin
    reset_n = 1'b0;
    err_status = '0;
    bus.sclk = 1'b0; bus.sdi = 1'b0; bus.le = 1'b0; bus.oe_n = 1'b1;
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(2);

    expect_val("rst_out_on", K_OUT, 16'h0000);
    expect_val("rst_cfg",    K_CFG, 16'h00FF);
    expect_val("rst_special", K_SPC, 16'h0000);
    expect_val("rst_sdo",    K_SDO, 16'h0000);

    // Normal load
    shift_word(1'b0, 16'hA5C3, 16);
    expect_val("norm_pre_latch", K_OUT, 16'h0000);
    le_pulse();
    expect_val("norm_out_on", K_OUT, 16'hA5C3);
    set_oe(1'b1);
    expect_val("norm_oe_high", K_OUT, 16'h0000);

    // Switch to special; step-4 le pulse must not touch out_data
    handshake(1'b1);
    expect_val("to_special", K_SPC, 16'h0001);
    set_oe(1'b0);
    expect_val("special_out_data_kept", K_OUT, 16'hA5C3);
    set_oe(1'b1);
    shift_word(1'b1, 16'h003C, 8);
    le_pulse();
    expect_val("cfg_load", K_CFG, 16'h003C);

    // Staying special: step-4 le pulse must not latch cfg
    handshake(1'b1);
    expect_val("stay_special", K_SPC, 16'h0001);
    expect_val("cfg_step4_suppressed", K_CFG, 16'h003C);

    // Error readback with three low edges
    err_status = 16'h0081;
    exp_sdo = 16'h0081;
    for (int i = 0; i < 3; i++) bit_step(1'b0, 1'b0, 1'b0);
    bit_step(1'b1, 1'b0, 1'b0);
    expect_val("err_sdo_0", K_SDO, {15'h0, exp_sdo[15]});
    for (int k = 1; k < 16; k++) begin
      bit_step(1'b1, 1'b0, 1'b0);
      expect_val($sformatf("err_sdo_%0d", k), K_SDO, {15'h0, exp_sdo[15-k]});
    end

    // Only two low edges: no parallel load
    for (int i = 0; i < 2; i++) bit_step(1'b0, 1'b0, 1'b0);
    err_status = 16'hFFFF;
    bit_step(1'b1, 1'b0, 1'b0);
    expect_val("no_arm_sdo_a", K_SDO, 16'h0000);
    bit_step(1'b1, 1'b0, 1'b0);
    expect_val("no_arm_sdo_b", K_SDO, 16'h0000);

    // Broken handshake: oe_n high where step 2 wants it low
    for (int i = 0; i < 5; i++) bit_step(1'b1, 1'b0, 1'b0);
    expect_val("broken_keeps_special", K_SPC, 16'h0001);
    // The last broken step counted as step 1, so steps 2..5 complete a switch to normal
    bit_step(1'b0, 1'b0, 1'b0);
    bit_step(1'b1, 1'b0, 1'b0);
    bit_step(1'b1, 1'b0, 1'b0);
    bit_step(1'b1, 1'b0, 1'b0);
    expect_val("back_to_normal", K_SPC, 16'h0000);
    expect_val("cfg_retained", K_CFG, 16'h003C);
    set_oe(1'b0);
    expect_val("normal_out_data_kept", K_OUT, 16'hA5C3);
    set_oe(1'b1);

    // Reset after step 3 of a special switch
    bit_step(1'b1, 1'b0, 1'b0);
    bit_step(1'b0, 1'b0, 1'b0);
    bit_step(1'b1, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    wait_clk(3);
    reset_n = 1'b1;
    set_oe(1'b0);
    expect_val("rst_mid_out_on", K_OUT, 16'h0000);
    expect_val("rst_mid_cfg", K_CFG, 16'h00FF);
    expect_val("rst_mid_special", K_SPC, 16'h0000);
    set_oe(1'b1);
    bit_step(1'b1, 1'b1, 1'b0);
    bit_step(1'b1, 1'b0, 1'b0);
    expect_val("rst_no_switch", K_SPC, 16'h0000);
    expect_val("rst_no_switch_cfg", K_CFG, 16'h00FF);

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
